mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter N, default 32, giving the operand width; N is even and at least 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port Start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 SHALL have port Op, input, 2 bits: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with Start.
REQ-006 SHALL have ports A and B, input, N bits each: multiplicand/multiplier or dividend/divisor; sampled with Start.
REQ-007 SHALL have port Busy, output, 1 bit: high while an operation is in progress.
REQ-008 SHALL have port Done, output, 1 bit: one-cycle pulse when Hi/Lo/DivZero hold a new result.
REQ-009 SHALL have ports Hi and Lo, output, N bits each: MIPS HI/LO result registers.
REQ-010 SHALL have port DivZero, output, 1 bit: the last divide had B == 0.

Function
REQ-011 SHALL implement states IDLE, RUN and FIX.
REQ-012 In IDLE with Start=1 at edge E0, SHALL latch Op, A and B, clear the iteration count, and enter RUN.
REQ-013 SHALL perform exactly one iteration per cycle in RUN: multiply is shift-add, LSB first; divide is restoring, MSB first, on N-bit magnitudes.
REQ-014 SHALL leave RUN for FIX at edge EN, after N iterations.
REQ-015 At edge E(N+1), FIX SHALL apply sign correction, write Hi/Lo/DivZero, and return to IDLE.
REQ-016 Busy SHALL be high from after E0 until E(N+1).
REQ-017 Done SHALL be high for exactly the cycle after E(N+1).
REQ-018 SHALL give a latency of N+1 clock edges from Start sample to result, independent of operand values.
REQ-019 Start while Busy=1 SHALL be ignored; it is neither queued nor corrupting.
REQ-020 Start during the Done cycle SHALL be accepted, giving back-to-back operation.
REQ-021 Changes on A, B or Op after E0 SHALL NOT affect the operation in flight.
REQ-022 Hi, Lo and DivZero SHALL hold their values, except at a FIX edge or reset.
REQ-023 MULTU SHALL give {Hi,Lo} = 2N-bit unsigned product.
REQ-024 MULT SHALL give {Hi,Lo} = 2N-bit two's-complement product, exact for all inputs, including (-2^(N-1))*(-2^(N-1)).
REQ-025 DIVU SHALL give Lo = unsigned quotient and Hi = unsigned remainder.
REQ-026 DIV SHALL give Lo = quotient truncated toward zero and Hi = remainder with the sign of A, such that A = B*Lo + Hi.
REQ-027 DIV of -2^(N-1) by -1 SHALL give Lo = 2^(N-1) (wrapped) and Hi = 0, with DivZero=0.
REQ-028 A divide with B == 0 SHALL keep the normal latency and give Lo = all ones, Hi = A unmodified, DivZero=1.
REQ-029 Any multiply, and any divide with B != 0, SHALL write DivZero=0 at FIX.
REQ-030 Signed magnitude conversion SHALL take the negation of -2^(N-1) as an unsigned N-bit value, so no overflow is lost.

Reset
REQ-031 reset_n low SHALL immediately force IDLE, Busy=0, Done=0, Hi=0, Lo=0, DivZero=0, and clear the internal count and operand registers.
REQ-032 Reset mid-operation SHALL discard the operation and produce no Done pulse.
REQ-033 The first Start after reset_n rises SHALL be accepted at the first rising edge with reset_n high.

Verification
REQ-034 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Done 33 edges after Start sample, with Hi=0xFFFFFFFE, Lo=0x00000001, DivZero=0.
REQ-035 MULT A=0x80000000, B=0x80000000 -> Hi=0x40000000, Lo=0x00000000; MULT A=-3, B=7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
REQ-036 DIV A=-7, B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
REQ-037 DIVU A=0x12345678, B=0 -> Lo=0xFFFFFFFF, Hi=0x12345678, DivZero=1, with the same 33-edge latency; a following MULTU clears DivZero.
REQ-038 Start pulsed mid-RUN with different A/B -> ignored, and the first result is unchanged; Start in the Done cycle -> second op accepted, Busy rises next cycle.
REQ-039 reset_n asserted at iteration 10 -> Busy=0 and Hi=Lo=0 asynchronously, no Done; a new MULTU 5*6 after release -> Lo=30, Hi=0.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative MIPS-style multiply/divide unit: shift-add multiply and restoring divide,
// one iteration per clock, fixed latency of N+1 edges from Start to result.
module mul_div_unit #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         Start,
   input  logic [1:0]   Op,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         Busy,
   output logic         Done,
   output logic [N-1:0] Hi,
   output logic [N-1:0] Lo,
   output logic         DivZero
);

   localparam int          CW        = $clog2(N) + 1;
   localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);
   localparam logic [CW-1:0] ONE_CW    = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [N-1:0]  ONE_N     = {{(N-1){1'b0}}, 1'b1};
   localparam logic [2*N-1:0] ONE_2N   = {{(2*N-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIX  = 2'b10
   } state_t;

   state_t          state_r;
   state_t          state_next_s;

   logic [1:0]      op_r;
   logic [N-1:0]    mcand_r;
   logic [N-1:0]    work_hi_r;
   logic [N-1:0]    work_lo_r;
   logic [N-1:0]    a_raw_r;
   logic            neg_main_r;
   logic            neg_rem_r;
   logic            b_zero_r;
   logic [CW-1:0]   count_r;

   logic [N:0]      mul_sum_s;
   logic [N:0]      div_shift_s;
   logic [N-1:0]    div_rem_s;
   logic            div_ge_s;
   logic [2*N-1:0]  prod_s;
   logic [N-1:0]    fix_hi_s;
   logic [N-1:0]    fix_lo_s;

   // Magnitude of an operand; -2^(N-1) maps to 2^(N-1) as an unsigned value.
   function automatic logic [N-1:0] mag_n(input logic [N-1:0] x, input logic is_signed);
      if (is_signed && x[N-1]) begin
         mag_n = ~x + ONE_N;
      end else begin
         mag_n = x;
      end
   endfunction

   function automatic logic [N-1:0] neg_n(input logic [N-1:0] x);
      neg_n = ~x + ONE_N;
   endfunction

   function automatic logic [2*N-1:0] neg_2n(input logic [2*N-1:0] x);
      neg_2n = ~x + ONE_2N;
   endfunction

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (Start) begin
               state_next_s = RUN;
            end else begin
               state_next_s = IDLE;
            end
         end
         RUN: begin
            if (count_r == LAST_ITER) begin
               state_next_s = FIX;
            end else begin
               state_next_s = RUN;
            end
         end
         FIX:     state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // One iteration step: multiply adds into the upper half and shifts right,
   // divide shifts the dividend bit into the remainder and trial-subtracts.
   always_comb begin
      mul_sum_s   = {1'b0, work_hi_r} + (work_lo_r[0] ? {1'b0, mcand_r} : {(N+1){1'b0}});
      div_shift_s = {work_hi_r, work_lo_r[N-1]};
      div_ge_s    = (div_shift_s >= {1'b0, mcand_r});
      div_rem_s   = div_shift_s[N-1:0] - mcand_r;
   end

   // Sign correction and divide-by-zero override applied in FIX
   always_comb begin
      prod_s   = {work_hi_r, work_lo_r};
      fix_hi_s = work_hi_r;
      fix_lo_s = work_lo_r;
      if (op_r[1]) begin
         if (b_zero_r) begin
            fix_hi_s = a_raw_r;
            fix_lo_s = {N{1'b1}};
         end else begin
            fix_lo_s = neg_main_r ? neg_n(work_lo_r) : work_lo_r;
            fix_hi_s = neg_rem_r  ? neg_n(work_hi_r) : work_hi_r;
         end
      end else begin
         if (neg_main_r) begin
            prod_s = neg_2n({work_hi_r, work_lo_r});
         end else begin
            prod_s = {work_hi_r, work_lo_r};
         end
         fix_hi_s = prod_s[2*N-1:N];
         fix_lo_s = prod_s[N-1:0];
      end
   end

   // Operand capture, iteration datapath and result registers.
   // B's magnitude is the multiplicand/divisor and A's the multiplier/dividend;
   // the product is symmetric so one capture path serves both operations.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_r       <= 2'b00;
         mcand_r    <= {N{1'b0}};
         work_hi_r  <= {N{1'b0}};
         work_lo_r  <= {N{1'b0}};
         a_raw_r    <= {N{1'b0}};
         neg_main_r <= 1'b0;
         neg_rem_r  <= 1'b0;
         b_zero_r   <= 1'b0;
         count_r    <= {CW{1'b0}};
         Hi         <= {N{1'b0}};
         Lo         <= {N{1'b0}};
         DivZero    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (Start) begin
                  op_r       <= Op;
                  mcand_r    <= mag_n(B, Op[0]);
                  work_hi_r  <= {N{1'b0}};
                  work_lo_r  <= mag_n(A, Op[0]);
                  a_raw_r    <= A;
                  neg_main_r <= Op[0] & (A[N-1] ^ B[N-1]);
                  neg_rem_r  <= Op[0] & A[N-1];
                  b_zero_r   <= (B == {N{1'b0}});
                  count_r    <= {CW{1'b0}};
               end
            end
            RUN: begin
               if (op_r[1]) begin
                  if (div_ge_s) begin
                     work_hi_r <= div_rem_s;
                     work_lo_r <= {work_lo_r[N-2:0], 1'b1};
                  end else begin
                     work_hi_r <= div_shift_s[N-1:0];
                     work_lo_r <= {work_lo_r[N-2:0], 1'b0};
                  end
               end else begin
                  work_hi_r <= mul_sum_s[N:1];
                  work_lo_r <= {mul_sum_s[0], work_lo_r[N-1:1]};
               end
               count_r <= count_r + ONE_CW;
            end
            FIX: begin
               Hi      <= fix_hi_s;
               Lo      <= fix_lo_s;
               DivZero <= op_r[1] & b_zero_r;
            end
            default: begin
               count_r <= {CW{1'b0}};
            end
         endcase
      end
   end

   // Busy spans the whole operation; Done pulses for the cycle after FIX
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         Busy <= 1'b0;
         Done <= 1'b0;
      end else begin
         Busy <= (state_next_s != IDLE);
         Done <= (state_r == FIX);
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomised self-checking bench for mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;

   localparam int N = 32;
   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_MULT  = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_DIV   = 2'b11;

   logic         clk;
   logic         reset_n;
   logic         Start;
   logic [1:0]   Op;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic         Busy;
   logic         Done;
   logic [N-1:0] Hi;
   logic [N-1:0] Lo;
   logic         DivZero;

   int           n_checks;
   int           n_fail;
   logic [N-1:0] exp_hi;
   logic [N-1:0] exp_lo;
   logic         exp_dz;

   mul_div_unit #(.N(N)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .Start   (Start),
      .Op      (Op),
      .A       (A),
      .B       (B),
      .Busy    (Busy),
      .Done    (Done),
      .Hi      (Hi),
      .Lo      (Lo),
      .DivZero (DivZero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: plain 64-bit arithmetic on the MIPS definitions
   task automatic model(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
      longint unsigned pu;
      longint          ps, q, r;
      int              sa, sb;
      sa = a;
      sb = b;
      exp_dz = 1'b0;
      case (op)
         OP_MULTU: begin
            pu = {32'h0, a} * {32'h0, b};
            {exp_hi, exp_lo} = pu;
         end
         OP_MULT: begin
            ps = longint'(sa) * longint'(sb);
            {exp_hi, exp_lo} = ps;
         end
         default: begin
            if (b == 32'h0) begin
               exp_lo = 32'hFFFF_FFFF;
               exp_hi = a;
               exp_dz = 1'b1;
            end else if (op == OP_DIVU) begin
               exp_lo = a / b;
               exp_hi = a % b;
            end else begin
               q = longint'(sa) / longint'(sb);
               r = longint'(sa) % longint'(sb);
               exp_lo = q[31:0];
               exp_hi = r[31:0];
            end
         end
      endcase
   endtask

   // Present Start for one edge, then scramble the inputs to prove they were latched
   task automatic issue(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
      Start = 1'b1;
      Op    = op;
      A     = a;
      B     = b;
      model(op, a, b);
      @(posedge clk);
      #1;
      Start = 1'b0;
      Op    = 2'($urandom);
      A     = $urandom;
      B     = $urandom;
      check_eq("busy_after_start", 64'(Busy), 64'd1);
   endtask

   // Wait for Done with a bound; optionally pulse Start with new operands mid-run
   task automatic wait_done(input bit disturb);
      int edges;
      edges = 0;
      while (Done !== 1'b1 && edges < 3 * N) begin
         if (disturb && edges == 10) begin
            Start = 1'b1;
            A     = ~A;
            B     = B + 32'd3;
            Op    = ~Op;
         end else begin
            Start = 1'b0;
         end
         @(posedge clk);
         #1;
         edges++;
      end
      Start = 1'b0;
      check_eq("latency", 64'(edges), 64'(N + 1));
      check_eq("busy_at_done", 64'(Busy), 64'd0);
      check_eq("hi", 64'(Hi), 64'(exp_hi));
      check_eq("lo", 64'(Lo), 64'(exp_lo));
      check_eq("divzero", 64'(DivZero), 64'(exp_dz));
   endtask

   // Idle cycle after a result: Done must drop and results must hold
   task automatic idle_check();
      @(posedge clk);
      #1;
      check_eq("done_single_pulse", 64'(Done), 64'd0);
      check_eq("hi_hold", 64'(Hi), 64'(exp_hi));
      check_eq("lo_hold", 64'(Lo), 64'(exp_lo));
   endtask

   initial begin
      logic [1:0]   op;
      logic [N-1:0] a, b;
      int           sel;
      bit           seen_done;
      n_checks = 0;
      n_fail   = 0;
      reset_n  = 1'b0;
      Start    = 1'b0;
      Op       = 2'b00;
      A        = 32'h0;
      B        = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_busy", 64'(Busy), 64'd0);
      check_eq("rst_done", 64'(Done), 64'd0);
      check_eq("rst_hi", 64'(Hi), 64'd0);
      check_eq("rst_lo", 64'(Lo), 64'd0);
      check_eq("rst_divzero", 64'(DivZero), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Directed corner cases
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done(1'b0); idle_check();
      issue(OP_MULT,  32'h8000_0000, 32'h8000_0000); wait_done(1'b0); idle_check();
      issue(OP_MULT,  -32'sd3, 32'sd7);              wait_done(1'b0); idle_check();
      issue(OP_DIV,   -32'sd7, 32'sd2);              wait_done(1'b0); idle_check();
      issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF); wait_done(1'b0); idle_check();
      issue(OP_DIVU,  32'h1234_5678, 32'h0);         wait_done(1'b0); idle_check();
      issue(OP_MULTU, 32'h0000_0003, 32'h0000_0004); wait_done(1'b0); idle_check();

      // Start mid-run is ignored; Start in the Done cycle is accepted
      issue(OP_DIVU, 32'hDEAD_BEEF, 32'h0000_1234);  wait_done(1'b1);
      issue(OP_DIV,  32'h8000_0000, 32'h0000_0000);  wait_done(1'b0); idle_check();

      // Asynchronous reset during iteration 10
      issue(OP_MULTU, 32'hCAFE_F00D, 32'h1357_9BDF);
      repeat (9) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("arst_busy", 64'(Busy), 64'd0);
      check_eq("arst_hi", 64'(Hi), 64'd0);
      check_eq("arst_lo", 64'(Lo), 64'd0);
      seen_done = 1'b0;
      for (int i = 0; i < N + 4; i++) begin
         @(posedge clk);
         #1;
         if (Done === 1'b1) seen_done = 1'b1;
      end
      check_eq("arst_no_done", 64'(seen_done), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      issue(OP_MULTU, 32'd5, 32'd6);
      wait_done(1'b0);
      check_eq("post_reset_lo30", 64'(Lo), 64'd30);

      // Randomised operations, mixing back-to-back and gapped issue
      for (int k = 0; k < 60; k++) begin
         op  = 2'($urandom_range(0, 3));
         a   = $urandom;
         b   = $urandom;
         sel = $urandom_range(0, 7);
         case (sel)
            0:       b = 32'h0;
            1:       a = 32'h8000_0000;
            2:       b = 32'hFFFF_FFFF;
            3:       b = 32'($urandom_range(1, 15));
            default: ;
         endcase
         if ($urandom_range(0, 1) == 0) idle_check();
         issue(op, a, b);
         wait_done(k % 7 == 3);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
